irda_dma_bridge: RTL

// DMA service engine downstream of irda_top's dma_req_t_o/dma_req_r_o.

---
 rtl/irda_dma_bridge_pkg.sv | 16 +
 rtl/irda_dma_bridge_wdog.sv | 27 ++
 rtl/irda_dma_bridge.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/irda_dma_bridge_pkg.sv
// Shared state encoding and default FIFO register addresses for the IrDA DMA bridge.
package irda_dma_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_HOLD = 3'd3,
    ST_ACK  = 3'd4,
    ST_GAP  = 3'd5
  } dma_state_e;

  localparam logic [3:0] TXFIFO_ADDR_DEF = 4'h0;
  localparam logic [3:0] RXFIFO_ADDR_DEF = 4'h0;

endpackage

// File: rtl/irda_dma_bridge_wdog.sv
// Bus watchdog: a down-counter reloaded while idle; expires on the (2**TMO_W-1)th enabled cycle.
module irda_dma_wdog #(
  parameter int TMO_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Loaded one short of the full timeout so the terminal compare lands on cycle 2**TMO_W-1.
  localparam logic [TMO_W-1:0] LOAD = TMO_W'((1 << TMO_W) - 2);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= LOAD;
    end else if (enable && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = enable && (cnt == '0);

endmodule

// File: rtl/irda_dma_bridge.sv
// WISHBONE master that services irda_top DMA requests: source stream -> TX FIFO, RX FIFO -> sink stream.
// state | meaning: IDLE wait/arbitrate, WR bus write, RD bus read, HOLD sink stall, ACK dma ack, GAP req settle
module irda_dma_bridge
  import irda_dma_bridge_pkg::*;
#(
  parameter logic [3:0] TXFIFO_ADDR = TXFIFO_ADDR_DEF,
  parameter logic [3:0] RXFIFO_ADDR = RXFIFO_ADDR_DEF,
  parameter int         LEN_W       = 16,
  parameter int         TMO_W       = 8
) (
  input  logic             clk,
  input  logic             wb_rst_i,
  output logic [3:0]       m_wb_addr_o,
  output logic [31:0]      m_wb_dat_o,
  input  logic [31:0]      m_wb_dat_i,
  output logic             m_wb_we_o,
  output logic             m_wb_stb_o,
  output logic             m_wb_cyc_o,
  input  logic             m_wb_ack_i,
  input  logic             dma_req_t_i,
  output logic             dma_ack_t_o,
  input  logic             dma_req_r_i,
  output logic             dma_ack_r_o,
  input  logic [31:0]      tx_dat_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [31:0]      rx_dat_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  input  logic [LEN_W-1:0] tx_len_i,
  input  logic             tx_start_i,
  input  logic [LEN_W-1:0] rx_len_i,
  input  logic             rx_start_i,
  output logic             tx_busy_o,
  output logic             rx_busy_o,
  output logic             tx_done_o,
  output logic             rx_done_o,
  output logic             err_o
);

  dma_state_e       state, state_nxt;
  logic             svc_rx, svc_rx_nxt;
  logic             bus_q;
  logic [LEN_W-1:0] tx_cnt, rx_cnt;
  logic             tx_done_z, rx_done_z;
  logic [31:0]      rx_hold;
  logic             err;
  logic             in_bus, expired, abort, tx_accept, rx_accept;

  assign in_bus = (state == ST_WR) || (state == ST_RD);

  irda_dma_wdog #(.TMO_W(TMO_W)) u_wdog (
    .clk     (clk),
    .rst     (wb_rst_i),
    .clear   (!in_bus),
    .enable  (in_bus),
    .expired (expired)
  );

  // A late ack on the terminal cycle still completes the word.
  assign abort     = expired && !m_wb_ack_i;
  assign tx_busy_o = (tx_cnt != '0);
  assign rx_busy_o = (rx_cnt != '0);
  assign tx_accept = tx_start_i && !tx_busy_o && !abort;
  assign rx_accept = rx_start_i && !rx_busy_o && !abort;

  always_comb begin
    state_nxt   = state;
    svc_rx_nxt  = svc_rx;
    m_wb_addr_o = 4'h0;
    m_wb_dat_o  = 32'h0;
    m_wb_we_o   = 1'b0;
    tx_ready_o  = 1'b0;
    rx_valid_o  = 1'b0;
    dma_ack_t_o = 1'b0;
    dma_ack_r_o = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_busy_o && dma_req_r_i) begin
          state_nxt  = ST_RD;
          svc_rx_nxt = 1'b1;
        end else if (tx_busy_o && dma_req_t_i && tx_valid_i) begin
          state_nxt  = ST_WR;
          svc_rx_nxt = 1'b0;
        end
      end
      ST_WR: begin
        m_wb_we_o   = 1'b1;
        m_wb_addr_o = TXFIFO_ADDR;
        m_wb_dat_o  = tx_dat_i;
        if (m_wb_ack_i) begin
          tx_ready_o = 1'b1;
          state_nxt  = ST_ACK;
        end else if (expired) begin
          state_nxt = ST_GAP;
        end
      end
      ST_RD: begin
        m_wb_addr_o = RXFIFO_ADDR;
        if (m_wb_ack_i)   state_nxt = ST_HOLD;
        else if (expired) state_nxt = ST_GAP;
      end
      ST_HOLD: begin
        rx_valid_o = 1'b1;
        if (rx_ready_i) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        dma_ack_r_o = svc_rx;
        dma_ack_t_o = !svc_rx;
        state_nxt   = ST_GAP;
      end
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign m_wb_cyc_o = bus_q;
  assign m_wb_stb_o = bus_q;
  assign rx_dat_o   = rx_hold;
  assign err_o      = err;
  assign tx_done_o  = (dma_ack_t_o && tx_cnt == LEN_W'(1)) || tx_done_z;
  assign rx_done_o  = (dma_ack_r_o && rx_cnt == LEN_W'(1)) || rx_done_z;

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      svc_rx    <= 1'b0;
      bus_q     <= 1'b0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      tx_done_z <= 1'b0;
      rx_done_z <= 1'b0;
      rx_hold   <= 32'h0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      svc_rx    <= svc_rx_nxt;
      bus_q     <= (state_nxt == ST_WR) || (state_nxt == ST_RD);
      tx_done_z <= 1'b0;
      rx_done_z <= 1'b0;

      if (state == ST_RD && m_wb_ack_i) rx_hold <= m_wb_dat_i;

      if (abort)                       err <= 1'b1;
      else if (tx_accept || rx_accept) err <= 1'b0;

      if (abort && !svc_rx) begin
        tx_cnt <= '0;
      end else if (tx_accept) begin
        tx_cnt    <= tx_len_i;
        tx_done_z <= (tx_len_i == '0);
      end else if (dma_ack_t_o) begin
        tx_cnt <= tx_cnt - 1'b1;
      end

      if (abort && svc_rx) begin
        rx_cnt <= '0;
      end else if (rx_accept) begin
        rx_cnt    <= rx_len_i;
        rx_done_z <= (rx_len_i == '0);
      end else if (dma_ack_r_o) begin
        rx_cnt <= rx_cnt - 1'b1;
      end
    end
  end

endmodule
